// File: rtl/idli_uart_tx_m.sv
// idli_uart_tx_m
//   Packs the execute stage's nibble-serial UART TX stream into bytes, low nibble
//   first. The bytes are queued in a small FIFO and sent out as 8N1 frames: the line
//   idles high, then a start bit (0), 8 data bits LSB first and a stop bit (1), with
//   each bit held for CLKS_PER_BIT clocks.
//
// Parameters
//   FIFO_DEPTH    byte entries in the queue (power of two, >= 2)
//   CLKS_PER_BIT  clocks per UART bit (>= 1)
//
// Ports
//   i_uart_gck    core gated clock
//   i_ex_rst_n    asynchronous active-low reset
//   i_uart_vld    TX nibble valid
//   i_uart_data   TX nibble
//   i_uart_ctr0   0 = low nibble, 1 = high nibble (high nibble completes a byte)
//   o_uart_space  at least two free FIFO entries, enough for a full 16-bit word
//   o_uart_busy   FIFO non-empty or a frame in progress
//   o_uart_ovf    sticky: a byte was dropped because the FIFO was full
//   o_uart_tx     serial line
module idli_uart_tx_m #(
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_uart_gck,
    input  logic       i_ex_rst_n,
    input  logic       i_uart_vld,
    input  logic [3:0] i_uart_data,
    input  logic       i_uart_ctr0,
    output logic       o_uart_space,
    output logic       o_uart_busy,
    output logic       o_uart_ovf,
    output logic       o_uart_tx
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BW-1:0] BCTR_MAX  = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] SPACE_MAX = CW'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t        state;
    logic [BW-1:0] bctr;
    logic [2:0]    bidx;
    logic [7:0]    shift_q;
    logic          tx_q;

    logic [3:0]    low_q;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf_q;

    logic fifo_ne;
    logic bit_end;
    logic pop;
    logic push_req;
    logic push_ok;

    assign fifo_ne  = (count != '0);
    // With CLKS_PER_BIT == 1 the counter never leaves 0, so every cycle ends a bit.
    assign bit_end  = (bctr == BCTR_MAX);
    // The serialiser takes the head either from IDLE or straight out of the last
    // stop-bit cycle, which gives back-to-back frames with no idle gap.
    assign pop      = fifo_ne && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
    assign push_req = i_uart_vld && i_uart_ctr0;
    // A full FIFO still accepts the byte when the head leaves on the same edge.
    assign push_ok  = push_req && ((count != DEPTH_CNT) || pop);

    // Byte assembly and FIFO bookkeeping.
    always_ff @(posedge i_uart_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            low_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every block sees
            // the pre-edge values regardless of evaluation order.
            if (i_uart_vld && !i_uart_ctr0) begin
                low_q <= i_uart_data;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_req && !push_ok) begin
                ovf_q <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and count are reset, so
    // stale entries are never read and reset stays off the wide data path.
    always_ff @(posedge i_uart_gck) begin
        if (push_ok) begin
            mem[wr_ptr] <= {i_uart_data, low_q};
        end
    end

    // Serialiser. tx_q registers the current state's line level, so the line
    // follows the state by one clock and each bit still lasts CLKS_PER_BIT clocks.
    always_ff @(posedge i_uart_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            state   <= ST_IDLE;
            bctr    <= '0;
            bidx    <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (fifo_ne) begin
                        shift_q <= mem[rd_ptr];
                        bctr    <= '0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    tx_q <= 1'b0;
                    bctr <= bit_end ? '0 : bctr + 1'b1;
                    if (bit_end) begin
                        bidx  <= '0;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    tx_q <= shift_q[0];
                    bctr <= bit_end ? '0 : bctr + 1'b1;
                    if (bit_end) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        bidx    <= bidx + 1'b1;
                        if (bidx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    tx_q <= 1'b1;
                    bctr <= bit_end ? '0 : bctr + 1'b1;
                    if (bit_end) begin
                        if (fifo_ne) begin
                            shift_q <= mem[rd_ptr];
                            state   <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign o_uart_space = (count <= SPACE_MAX);
    assign o_uart_busy  = fifo_ne || (state != ST_IDLE);
    assign o_uart_ovf   = ovf_q;
    assign o_uart_tx    = tx_q;

endmodule

// File: tb/tb_idli_uart_tx_m.sv
// tb_idli_uart_tx_m
//   Drives two instances of idli_uart_tx_m from the same nibble stream: one with
//   CLKS_PER_BIT = 16 and one with CLKS_PER_BIT = 1, both with FIFO_DEPTH = 4.
//   Each instance is compared every cycle against a frame-timing reference model;
//   a vector table and hand-written sequences cover the specific corner cases.
module tb_idli_uart_tx_m;

    localparam int DEPTH = 4;
    localparam int CPB0  = 16;
    localparam int CPB1  = 1;

    logic       clk;
    logic       rst_n;
    logic       vld;
    logic [3:0] data;
    logic       ctr0;
    logic [1:0] tx_a;
    logic [1:0] busy_a;
    logic [1:0] space_a;
    logic [1:0] ovf_a;

    int n_checks;
    int n_errors;

    idli_uart_tx_m #(.FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB0)) dut16 (
        .i_uart_gck  (clk),
        .i_ex_rst_n  (rst_n),
        .i_uart_vld  (vld),
        .i_uart_data (data),
        .i_uart_ctr0 (ctr0),
        .o_uart_space(space_a[0]),
        .o_uart_busy (busy_a[0]),
        .o_uart_ovf  (ovf_a[0]),
        .o_uart_tx   (tx_a[0])
    );

    idli_uart_tx_m #(.FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB1)) dut1 (
        .i_uart_gck  (clk),
        .i_ex_rst_n  (rst_n),
        .i_uart_vld  (vld),
        .i_uart_data (data),
        .i_uart_ctr0 (ctr0),
        .o_uart_space(space_a[1]),
        .o_uart_busy (busy_a[1]),
        .o_uart_ovf  (ovf_a[1]),
        .o_uart_tx   (tx_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a byte queue plus the edge number at which the
    // current frame was taken. The line level is derived from the offset
    // into that frame: bit slot = offset / CLKS_PER_BIT.
    // ------------------------------------------------------------------
    logic [7:0] mq   [2][DEPTH];
    int         msz  [2];
    longint     mn   [2];
    longint     mfp  [2];
    logic [7:0] mfb  [2];
    logic [3:0] mlow [2];
    logic       m_tx [2];
    logic       m_busy [2];
    logic       m_space[2];
    logic       m_ovf  [2];

    task automatic model_reset(input int i);
        msz[i]     = 0;
        mn[i]      = 0;
        mfp[i]     = -1000;
        mfb[i]     = '0;
        mlow[i]    = '0;
        m_tx[i]    = 1'b1;
        m_busy[i]  = 1'b0;
        m_space[i] = 1'b1;
        m_ovf[i]   = 1'b0;
    endtask

    task automatic model_step(input int i, input logic v, input logic [3:0] d, input logic c0);
        longint c;
        longint off;
        int     b;
        c     = (i == 0) ? CPB0 : CPB1;
        mn[i] = mn[i] + 1;
        // Line level after this edge comes from the frame in flight before it.
        off = mn[i] - mfp[i] - 1;
        if (off >= 0 && off < 10 * c) begin
            b = int'(off / c);
            if (b == 0)      m_tx[i] = 1'b0;
            else if (b == 9) m_tx[i] = 1'b1;
            else             m_tx[i] = mfb[i][b-1];
        end else begin
            m_tx[i] = 1'b1;
        end
        // Take the next byte once the previous frame's 10 bits are used up.
        if (mn[i] >= mfp[i] + 10 * c && msz[i] > 0) begin
            mfb[i] = mq[i][0];
            for (int k = 0; k < DEPTH - 1; k++) mq[i][k] = mq[i][k+1];
            msz[i] = msz[i] - 1;
            mfp[i] = mn[i];
        end
        if (v && c0) begin
            if (msz[i] < DEPTH) begin
                mq[i][msz[i]] = {d, mlow[i]};
                msz[i]        = msz[i] + 1;
            end else begin
                m_ovf[i] = 1'b1;
            end
        end else if (v) begin
            mlow[i] = d;
        end
        m_busy[i]  = (mn[i] < mfp[i] + 10 * c) || (msz[i] != 0);
        m_space[i] = (DEPTH - msz[i]) >= 2;
    endtask

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic act, input logic exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("model tx cpb%0d", i == 0 ? CPB0 : CPB1),    tx_a[i],    m_tx[i]);
            check($sformatf("model busy cpb%0d", i == 0 ? CPB0 : CPB1),  busy_a[i],  m_busy[i]);
            check($sformatf("model space cpb%0d", i == 0 ? CPB0 : CPB1), space_a[i], m_space[i]);
            check($sformatf("model ovf cpb%0d", i == 0 ? CPB0 : CPB1),   ovf_a[i],   m_ovf[i]);
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model at the
    // rising edge, compare at the next falling edge.
    task automatic cycle(input logic v, input logic [3:0] d, input logic c0);
        vld  = v;
        data = d;
        ctr0 = c0;
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) model_step(i, v, d, c0);
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic send_byte(input logic [7:0] b);
        cycle(1'b1, b[3:0], 1'b0);
        cycle(1'b1, b[7:4], 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 4'h0, 1'b0);
    endtask

    // Asserts reset between clock edges and checks the outputs respond at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) model_reset(i);
        for (int i = 0; i < 2; i++) begin
            check("reset tx",    tx_a[i],    1'b1);
            check("reset busy",  busy_a[i],  1'b0);
            check("reset space", space_a[i], 1'b1);
            check("reset ovf",   ovf_a[i],   1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Vector table for the CLKS_PER_BIT = 1 instance: byte 0xA5 produces
    // 0,1,0,1,0,0,1,0,1,1 on consecutive cycles starting two edges after
    // the high nibble.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       vld;
        logic [3:0] data;
        logic       ctr0;
        logic       exp_tx;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        vld      = 1'b0;
        data     = 4'h0;
        ctr0     = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 2; i++) model_reset(i);
        #1 rst_n = 1'b0;

        vecs[0]  = '{vld: 1'b1, data: 4'h5, ctr0: 1'b0, exp_tx: 1'b1, exp_busy: 1'b0};
        vecs[1]  = '{vld: 1'b1, data: 4'hA, ctr0: 1'b1, exp_tx: 1'b1, exp_busy: 1'b1};
        vecs[2]  = '{vld: 1'b0, data: 4'h0, ctr0: 1'b0, exp_tx: 1'b1, exp_busy: 1'b1};
        vecs[3]  = '{vld: 1'b0, data: 4'h0, ctr0: 1'b0, exp_tx: 1'b0, exp_busy: 1'b1};
        vecs[4]  = '{vld: 1'b0, data: 4'h0, ctr0: 1'b0, exp_tx: 1'b1, exp_busy: 1'b1};
        vecs[5]  = '{vld: 1'b0, data: 4'h0, ctr0: 1'b0, exp_tx: 1'b0, exp_busy: 1'b1};
        vecs[6]  = '{vld: 1'b0, data: 4'h0, ctr0: 1'b0, exp_tx: 1'b1, exp_busy: 1'b1};
        vecs[7]  = '{vld: 1'b0, data: 4'h0, ctr0: 1'b0, exp_tx: 1'b0, exp_busy: 1'b1};
        vecs[8]  = '{vld: 1'b0, data: 4'h0, ctr0: 1'b0, exp_tx: 1'b0, exp_busy: 1'b1};
        vecs[9]  = '{vld: 1'b0, data: 4'h0, ctr0: 1'b0, exp_tx: 1'b1, exp_busy: 1'b1};
        vecs[10] = '{vld: 1'b0, data: 4'h0, ctr0: 1'b0, exp_tx: 1'b0, exp_busy: 1'b1};
        vecs[11] = '{vld: 1'b0, data: 4'h0, ctr0: 1'b0, exp_tx: 1'b1, exp_busy: 1'b1};
        vecs[12] = '{vld: 1'b0, data: 4'h0, ctr0: 1'b0, exp_tx: 1'b1, exp_busy: 1'b0};
        vecs[13] = '{vld: 1'b0, data: 4'h0, ctr0: 1'b0, exp_tx: 1'b1, exp_busy: 1'b0};

        @(negedge clk);
        do_reset();

        // Single-clock bit timing, table driven.
        for (int r = 0; r < 14; r++) begin
            cycle(vecs[r].vld, vecs[r].data, vecs[r].ctr0);
            check($sformatf("vec%0d tx", r),   tx_a[1],   vecs[r].exp_tx);
            check($sformatf("vec%0d busy", r), busy_a[1], vecs[r].exp_busy);
        end
        idle(170);

        // Byte 0x41: start bit two edges after the high nibble, busy for 160 cycles.
        send_byte(8'h41);
        cycle(1'b0, 4'h0, 1'b0);
        check("t1 tx before start", tx_a[0], 1'b1);
        cycle(1'b0, 4'h0, 1'b0);
        check("t1 start bit", tx_a[0], 1'b0);
        idle(158);
        check("t1 busy last cycle", busy_a[0], 1'b1);
        cycle(1'b0, 4'h0, 1'b0);
        check("t1 busy released", busy_a[0], 1'b0);
        idle(5);

        // 16-bit word 0x4241: two frames back to back.
        send_byte(8'h41);
        send_byte(8'h42);
        idle(158);
        cycle(1'b0, 4'h0, 1'b0);
        check("t2 first stop bit", tx_a[0], 1'b1);
        cycle(1'b0, 4'h0, 1'b0);
        check("t2 second start bit", tx_a[0], 1'b0);
        check("t2 busy between frames", busy_a[0], 1'b1);
        idle(170);

        // Six bytes back to back into a depth-4 FIFO: the sixth is dropped.
        for (int k = 0; k < 6; k++) send_byte(8'h30 + 8'(k));
        check("t3 space full", space_a[0], 1'b0);
        check("t3 ovf set", ovf_a[0], 1'b1);
        idle(5 * 160);
        check("t3 drained", busy_a[0], 1'b0);
        check("t3 ovf sticky", ovf_a[0], 1'b1);

        // Full FIFO, push lands on the STOP->START pop edge: accepted.
        do_reset();
        for (int k = 0; k < 5; k++) send_byte(8'h50 + 8'(k));
        idle(10 * CPB0 + 3 - 12);
        cycle(1'b1, 4'h9, 1'b0);
        check("t4 full before push", space_a[0], 1'b0);
        check("t4 ovf before push", ovf_a[0], 1'b0);
        cycle(1'b1, 4'h6, 1'b1);
        check("t4 ovf after push", ovf_a[0], 1'b0);
        check("t4 still full", space_a[0], 1'b0);
        idle(5 * 160 + 10);
        check("t4 drained", busy_a[0], 1'b0);
        check("t4 ovf clear", ovf_a[0], 1'b0);

        // Reset during data bit 3 with an overflowed FIFO behind it.
        do_reset();
        for (int k = 0; k < 6; k++) send_byte(8'hC0 + 8'(k));
        idle(60);
        check("t5 ovf before reset", ovf_a[0], 1'b1);
        check("t5 busy before reset", busy_a[0], 1'b1);
        do_reset();
        idle(400);
        check("t5 no frame after reset", busy_a[0], 1'b0);

        // Random nibble stream against the model.
        do_reset();
        cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0);
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        idle(6 * 160);
        check("rand drained", busy_a[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
